prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Serial program loader. Parses framed bytes from a ready/valid byte
//   source and writes the payload into program memory, holding the CPU
//   while memory contents are untrusted.
//
//   Frame: SYNC_BYTE, CNT_HI, CNT_LO, N data bytes, CHK
//          N-1 = {CNT_HI[3:0], CNT_LO}; CHK = sum of data bytes mod 256.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/valid/ready   byte input handshake (accept = valid & ready)
//   mem_addr/wdata/we     program memory write port, one cycle after accept
//   cpu_hold              CPU stall while a frame is in flight or has failed
//   done / error          result of the most recent frame
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        cnt_hi_q,    cnt_hi_d;
    logic [11:0]       byte_cnt_q,  byte_cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        acc_q,       acc_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              cpu_hold_q,  cpu_hold_d;
    logic              done_q,      done_d;
    logic              error_q,     error_d;

    logic accept;

    // The loader never back-pressures; ready simply tracks reset so it drops
    // immediately with rst_n and is up in the very first cycle afterwards.
    assign rx_ready = rst_n;
    assign accept   = rx_valid & rx_ready;

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;          // strobe only in the cycle after a data accept
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        if (accept) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // Non-sync bytes between frames are swallowed silently.
                    if (rx_data == SYNC_BYTE) begin
                        state_d    = S_CNT_HI;
                        cpu_hold_d = 1'b1;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                    end
                end
                S_CNT_HI: begin
                    if (rx_data[7:4] != 4'h0) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        cnt_hi_d = rx_data[3:0];
                        state_d  = S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    byte_cnt_d = {cnt_hi_q, rx_data};
                    addr_d     = '0;
                    acc_d      = 8'h00;
                    state_d    = S_DATA;
                end
                S_DATA: begin
                    // SYNC_BYTE here is payload; no re-sync inside DATA.
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = rx_data;
                    addr_d      = addr_q + 1'b1;   // wraps at 2^ADDR_W
                    acc_d       = acc_q + rx_data;
                    if (byte_cnt_q == 12'd0) state_d = S_CHK;
                    else                     byte_cnt_d = byte_cnt_q - 12'd1;
                end
                S_CHK: begin
                    if (rx_data == acc_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_hi_q    <= 4'h0;
            byte_cnt_q  <= 12'h000;
            addr_q      <= '0;
            acc_q       <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Directed + randomized bench for prog_loader. Expected writes are derived
//   from the frame definition: data byte i lands at address i mod 4096 in
//   the cycle after it is accepted, and the checksum is the byte sum mod 256.
module tb_prog_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] dat [4096];

    prog_loader #(.SYNC_BYTE(SYNC), .ADDR_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(rx_ready),  32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hold"},  32'(cpu_hold),  32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_error"}, 32'(error),     32'd0);
    endtask

    // Called #1 after a rising edge. Optional random idle gap (no write may
    // appear), then one accepted byte and a check of the resulting write port.
    task automatic send(input logic [7:0] b, input int gapmax, input bit exp_we,
                        input logic [11:0] exp_addr, input string tag);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk); #1;
            check({tag, "_gap_we"}, 32'(mem_we), 32'd0);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check({tag, "_we"}, 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_addr"},  32'(mem_addr),  32'(exp_addr));
            check({tag, "_wdata"}, 32'(mem_wdata), 32'(b));
        end
    endtask

    task automatic run_frame(input int n, input bit bad, input int gapmax, input string tag);
        int         sum;
        logic [7:0] chk;
        logic [11:0] nm1;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(dat[i]);
        chk = 8'(sum % 256);
        if (bad) chk = chk + 8'd1;
        nm1 = 12'(n - 1);
        send(SYNC, gapmax, 1'b0, 12'h0, {tag, "_sync"});
        check({tag, "_hold_on"},   32'(cpu_hold), 32'd1);
        check({tag, "_done_clr"},  32'(done),     32'd0);
        check({tag, "_error_clr"}, 32'(error),    32'd0);
        send({4'h0, nm1[11:8]}, gapmax, 1'b0, 12'h0, {tag, "_hi"});
        send(nm1[7:0],          gapmax, 1'b0, 12'h0, {tag, "_lo"});
        for (int i = 0; i < n; i++)
            send(dat[i], gapmax, 1'b1, 12'(i % 4096), {tag, "_data"});
        send(chk, gapmax, 1'b0, 12'h0, {tag, "_chk"});
        check({tag, "_done"},  32'(done),     32'(!bad));
        check({tag, "_error"}, 32'(error),    32'(bad));
        check({tag, "_hold"},  32'(cpu_hold), 32'(bad));
        @(posedge clk); #1;
        check({tag, "_idle_we"}, 32'(mem_we), 32'd0);
    endtask

    task automatic load_deadbeef();
        dat[0] = 8'hDE; dat[1] = 8'hAD; dat[2] = 8'hBE; dat[3] = 8'hEF;
    endtask

    initial begin
        logic [7:0] b;
        int         n;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;

        // Good 4-byte frame, then same payload with a wrong checksum.
        load_deadbeef();
        run_frame(4, 1'b0, 0, "good4");
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send(b, 0, 1'b0, 12'h0, "done_junk");
        end
        check("done_sticky", 32'(done), 32'd1);
        run_frame(4, 1'b1, 0, "bad4");

        // Illegal CNT_HI: straight to error, nothing written afterwards.
        send(SYNC,  0, 1'b0, 12'h0, "hdr_sync");
        send(8'h10, 0, 1'b0, 12'h0, "hdr_hi");
        check("hdr_error", 32'(error),    32'd1);
        check("hdr_hold",  32'(cpu_hold), 32'd1);
        check("hdr_done",  32'(done),     32'd0);
        send(8'h00, 0, 1'b0, 12'h0, "hdr_tail0");
        send(8'h03, 0, 1'b0, 12'h0, "hdr_tail1");
        send(8'hDE, 0, 1'b0, 12'h0, "hdr_tail2");
        check("hdr_error_stays", 32'(error), 32'd1);

        // Maximum frame: 4096 bytes of 01, checksum 00, last write at FFF.
        for (int i = 0; i < 4096; i++) dat[i] = 8'h01;
        run_frame(4096, 1'b0, 0, "max");

        // Reset in the middle of a frame after two data bytes.
        load_deadbeef();
        send(SYNC,  0, 1'b0, 12'h0, "mid_sync");
        send(8'h00, 0, 1'b0, 12'h0, "mid_hi");
        send(8'h03, 0, 1'b0, 12'h0, "mid_lo");
        send(dat[0], 0, 1'b1, 12'h000, "mid_d0");
        send(dat[1], 0, 1'b1, 12'h001, "mid_d1");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #3;
        rst_n = 1'b1;
        #1;
        check("midrst_ready", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        run_frame(4, 1'b0, 0, "after_rst");

        // Random payloads with a SYNC value embedded and random valid gaps.
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(40, 5));
            for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
            dat[2] = SYNC;
            run_frame(n, k[0], 3, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
